pll_lock_supervisor: RTL

//  Sits on the PLL's refclk/rst/locked interface and manages the PLL from the reference-clock side.
//  - Drives the PLL reset and qualifies its asynchronous locked flag.
//  - Releases core reset only after lock has been stable long enough.
//  - Re-pulses PLL reset on lock timeout and reasserts core reset on loss of lock.
//  - Runs on the 50 MHz reference clock, so it never depends on the PLL's own outputs.

---
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Supervises a PLL from its reference-clock side. Holds the PLL in reset
//   for a fixed pulse, waits for a qualified lock, requires the lock to stay
//   up for a stable window plus a hold window, then releases core reset.
//   Re-pulses the PLL reset when lock never arrives within the timeout, and
//   drops back to waiting (core in reset) on any loss of lock.
//   Everything runs on refclk, so the block never depends on PLL outputs.
//
// Ports
//   refclk       in   reference clock, sole clock of the block
//   rst_n        in   asynchronous active-low reset
//   locked       in   PLL lock flag, asynchronous to refclk
//   soft_req     in   refclk-domain pulse forcing a full PLL re-reset
//   pll_rst      out  PLL reset, active high
//   sys_reset    out  core reset, active high
//   ready        out  high only while in RUN
//   retry_count  out  lock timeouts since rst_n, saturating at 255
//   lol_count    out  losses of lock while in RUN, saturating at 255
//   state_dbg    out  current state encoding
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int HOLD_CYCLES         = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] retry_count,
  output logic [7:0] lol_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  // Terminal counts: a state lasting N cycles leaves when cnt == N-1,
  // since cnt is cleared on the entry edge.
  localparam logic [CNT_W-1:0] T_PLLRST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_STABLE = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_HOLD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_TMO    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             restart;
  logic             retry_inc, lol_inc;

  // ---------------------------------------------------------------------
  // locked synchronizer: shift register, cleared so reset never sees lock
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   locked_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_pipe[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Next-state logic. Priority: soft_req > lock drop > counter expiry.
  // In WAIT, lock is tested before the timeout so a lock arriving on the
  // timeout cycle wins.
  // ---------------------------------------------------------------------
  always_comb begin
    st_nxt    = state;
    restart   = 1'b0;
    retry_inc = 1'b0;
    lol_inc   = 1'b0;
    if (soft_req) begin
      st_nxt  = ST_PLLRST;
      restart = 1'b1;   // also restarts the pulse when already in PLLRST
    end else begin
      case (state)
        ST_PLLRST: if (cnt == T_PLLRST) st_nxt = ST_WAIT;
        ST_WAIT: begin
          if (locked_s) st_nxt = ST_STABLE;
          else if (cnt == T_TMO) begin
            st_nxt    = ST_PLLRST;
            retry_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s)           st_nxt = ST_WAIT;
          else if (cnt == T_STABLE) st_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (!locked_s)         st_nxt = ST_WAIT;
          else if (cnt == T_HOLD) st_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!locked_s) begin
            st_nxt  = ST_WAIT;
            lol_inc = 1'b1;
          end
        end
        default: st_nxt = ST_PLLRST;
      endcase
    end
  end

  assign cnt_clr = restart | (st_nxt != state);

  // ---------------------------------------------------------------------
  // State, cycle counter and registered Moore outputs. Outputs decode the
  // next state so they change on the same edge as the state register.
  // ---------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PLLRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= st_nxt;
      pll_rst   <= (st_nxt == ST_PLLRST);
      sys_reset <= (st_nxt != ST_RUN);
      ready     <= (st_nxt == ST_RUN);
      if (cnt_clr)              cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
    end
  end

  // Event counters, saturating at 255
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_count <= '0;
      lol_count   <= '0;
    end else begin
      if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      if (lol_inc && lol_count != 8'hFF)     lol_count   <= lol_count + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule
